mips_data_mem: RTL and testbench
================================

# mips_data_mem

Parametrised byte-addressable data memory for the MIPS datapath's MEM stage. It supports byte, halfword and word stores and loads, with sign or zero extension on loads, misalignment and range checking, and a one-cycle registered read. After reset, a hardware sweep zero-initialises the whole array before the first access is accepted.

## Interface
Parameters:
- DEPTH, 1024, number of 32-bit words (power of two, ≥ 4).
- IDX_W, $clog2(DEPTH), word-index width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- resetb  in  1  asynchronous, active-low reset.
- req  in  1  access request.
- we  in  1  1 = store, 0 = load; sampled with req.
- size  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- unsigned_ld  in  1  1 = zero-extend loads (lbu/lhu), 0 = sign-extend.
- addr  in  32  byte address.
- wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- ready  out  1  block can accept a request this cycle.
- rvalid  out  1  one-cycle pulse: rdata valid for an accepted load.
- rdata  out  32  extended load data.
- err  out  1  one-cycle pulse: the accepted request was illegal.

## Operation
- States:
  - INIT: counter walks word index 0..DEPTH-1, writing 32'h0 once per cycle; ready = 0.
  - RUN: ready = 1 permanently.
  - INIT→RUN: on the edge that clears index DEPTH-1. There is no return to INIT except via reset.
- Accept when req && ready; one request per cycle, no backpressure in RUN.
- Legality checks:
  - size = 11 is illegal.
  - Half with addr[0] = 1 is illegal.
  - Word with addr[1:0] ≠ 00 is illegal.
  - addr ≥ 4·DEPTH is illegal (out of range).
- Illegal request: no array change; err = 1 next cycle. For loads, rvalid = 1 and rdata = 0 that same cycle.
- Store: word index = addr[IDX_W+1:2]. Byte lanes selected by size and addr[1:0]:
  - byte: lane addr[1:0] gets wdata[7:0].
  - half: lanes {addr[1],0} and {addr[1],1} get wdata[15:0], little-endian.
  - word: all four lanes.
  - Unselected lanes are unchanged.
- Load: the selected byte or half is shifted to bit 0, then sign- or zero-extended per unsigned_ld. A word load returns the word unchanged, and unsigned_ld is ignored.
- req while ready = 0 is dropped: no effect, no response.

## Timing
- Reset values: ready 0, rvalid 0, rdata 32'h0, err 0, init counter 0, state INIT. Array contents are undefined until INIT completes.
- INIT takes DEPTH cycles. ready rises after the DEPTH-th rising edge following resetb deassertion.
- Load latency is 1 cycle: accepted at edge N, rvalid/rdata valid after edge N, sampled at edge N+1.
- Store commits at the accept edge. A load accepted on the next cycle to the same word returns the new data, with no forwarding needed.
- rdata holds its last value when rvalid = 0.
- err and rvalid last exactly one cycle per accepted request.
- Reset asserted mid-INIT or mid-access: all outputs return to reset values immediately, any pending response is discarded, and INIT restarts from index 0.

## Structure
- Shared package mips_mem_pkg holds:
  - mem_size_e enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL).
  - state enum (ST_INIT, ST_RUN).
  - function lane_mask(size, addr[1:0]) → 4-bit byte enable.
  - function load_extend(word, size, addr[1:0], unsigned_ld) → 32 bits.
- One natural sub-module: mips_mem_bytearray, a DEPTH×32 array with a 4-bit byte-write enable and a registered read port. The top holds the FSM, checks, extension and response registers.

## Test plan
- Reset release, DEPTH=16 → ready low for exactly 16 cycles. Then loads of all words return 0 with err = 0.
- sw 0x11223344 @0x8; lb @0x9 → 0x00000033; lb @0xB → 0x00000011; lbu @0xB → 0x00000011; sb 0xF0 @0xA then lb @0xA → 0xFFFFFFF0.
- sh 0x8001 @0x6; lh @0x6 → 0xFFFF8001; lhu @0x6 → 0x00008001; lw @0x4 keeps bytes 0x4–0x5 unchanged.
- Misaligned: lw @0x2 → rvalid = 1, err = 1, rdata = 0. sh @0x5 → err = 1, and word 1 is unchanged on readback. size = 11 → err = 1.
- Out of range, DEPTH=16: sw @0x40 → err = 1, and no word 0 alias write.
- Back-to-back: sw 0xDEADBEEF @0x0 at cycle N, lw @0x0 at N+1 → rdata 0xDEADBEEF at N+2. Reset asserted during INIT at index 7 → ready stays 0 for a further full 16 cycles.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the MEM-stage data memory: access sizes,
// controller states, byte-lane decode and load extension.
package mips_mem_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_ILL  = 2'b11
   } mem_size_e;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } mem_state_e;

   function automatic logic [3:0] lane_mask(input mem_size_e sz, input logic [1:0] off);
      logic [3:0] m;
      m = 4'b0000;
      case (sz)
         SZ_BYTE: m = 4'b0001 << off;
         SZ_HALF: m = off[1] ? 4'b1100 : 4'b0011;
         SZ_WORD: m = 4'b1111;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

   // Selected lane is shifted down to bit 0, then sign/zero extended.
   function automatic logic [31:0] load_extend(input logic [31:0] word, input mem_size_e sz,
                                               input logic [1:0] off, input logic uns);
      logic [31:0]        sh;
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic signed [31:0] ext;
      sh  = word >> {off, 3'b000};
      b   = sh[7:0];
      h   = sh[15:0];
      ext = 32'sd0;
      case (sz)
         SZ_BYTE: begin
            ext = b;
            if (uns) ext = {24'h0, sh[7:0]};
         end
         SZ_HALF: begin
            ext = h;
            if (uns) ext = {16'h0, sh[15:0]};
         end
         SZ_WORD: ext = word;
         default: ext = 32'sd0;
      endcase
      return ext;
   endfunction

endpackage

// File: rtl/mips_mem_bytearray.sv
// DEPTH x 32 storage with per-byte write enables and a registered read port.
// The read register only loads on re, so its output holds between loads.
module mips_mem_bytearray #(
   parameter int DEPTH = 1024,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic [3:0]       be,
   input  logic [IDX_W-1:0] widx,
   input  logic [31:0]      wdata,
   input  logic             re,
   input  logic [IDX_W-1:0] ridx,
   output logic [31:0]      rword
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (be[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
      end
      if (re) rword <= mem[ridx];
   end

endmodule

// File: rtl/mips_data_mem.sv
// Byte-addressable MEM-stage data memory: zero-fill sweep after reset, then
// byte/half/word accesses with legality checks and a one-cycle load response.
module mips_data_mem
   import mips_mem_pkg::*;
#(
   parameter  int DEPTH = 1024,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        resetb,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        unsigned_ld,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        ready,
   output logic        rvalid,
   output logic [31:0] rdata,
   output logic        err
);

   mem_state_e       state_q, state_d;
   logic [IDX_W-1:0] init_idx;

   mem_size_e        sz;
   logic             accept;
   logic             bad_align;
   logic             out_of_range;
   logic             illegal;

   logic [3:0]       wr_be;
   logic [IDX_W-1:0] wr_idx;
   logic [31:0]      wr_data;
   logic             rd_en;
   logic [31:0]      rd_word;

   logic             vld_p1;
   logic             err_p1;
   logic             ld_ok_p1;
   mem_size_e        size_p1;
   logic [1:0]       off_p1;
   logic             uns_p1;

   assign sz     = mem_size_e'(size);
   assign ready  = (state_q == ST_RUN);
   assign accept = req && ready;

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state_q  <= ST_INIT;
         init_idx <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_INIT) init_idx <= init_idx + IDX_W'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      if (state_q == ST_INIT && init_idx == IDX_W'(DEPTH - 1)) state_d = ST_RUN;
   end

   // Any address bit above the array's byte range means out of range.
   always_comb begin
      bad_align = 1'b0;
      case (sz)
         SZ_HALF: bad_align = addr[0];
         SZ_WORD: bad_align = |addr[1:0];
         SZ_ILL:  bad_align = 1'b1;
         default: bad_align = 1'b0;
      endcase
      out_of_range = |addr[31:IDX_W+2];
      illegal      = bad_align || out_of_range;
   end

   always_comb begin
      wr_be   = 4'b0000;
      wr_idx  = addr[IDX_W+1:2];
      wr_data = wdata;
      case (sz)
         SZ_BYTE: wr_data = {4{wdata[7:0]}};
         SZ_HALF: wr_data = {2{wdata[15:0]}};
         default: wr_data = wdata;
      endcase
      if (state_q == ST_INIT) begin
         wr_be   = 4'b1111;
         wr_idx  = init_idx;
         wr_data = 32'h0;
      end else if (accept && we && !illegal) begin
         wr_be = lane_mask(sz, addr[1:0]);
      end
      rd_en = accept && !we && !illegal;
   end

   mips_mem_bytearray #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_array (
      .clk   (clk),
      .be    (wr_be),
      .widx  (wr_idx),
      .wdata (wr_data),
      .re    (rd_en),
      .ridx  (addr[IDX_W+1:2]),
      .rword (rd_word)
   );

   // ---- stage p1: response registers, aligned with the array read word ----
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         vld_p1   <= 1'b0;
         err_p1   <= 1'b0;
         ld_ok_p1 <= 1'b0;
         size_p1  <= SZ_BYTE;
         off_p1   <= 2'b00;
         uns_p1   <= 1'b0;
      end else begin
         vld_p1 <= accept && !we;
         err_p1 <= accept && illegal;
         if (accept && !we) begin
            ld_ok_p1 <= !illegal;
            size_p1  <= sz;
            off_p1   <= addr[1:0];
            uns_p1   <= unsigned_ld;
         end
      end
   end

   // ld_ok_p1 is low after reset and after an illegal load, forcing zero.
   assign rdata  = ld_ok_p1 ? load_extend(rd_word, size_p1, off_p1, uns_p1) : 32'h0;
   assign rvalid = vld_p1;
   assign err    = err_p1;

endmodule

// File: tb/tb_mips_data_mem.sv
// Scoreboard bench for mips_data_mem at DEPTH=16: expected responses are queued
// as each access is driven and compared against the observed response.
module tb_mips_data_mem;

   logic        clk = 1'b0;
   logic        resetb;
   logic        req;
   logic        we;
   logic [1:0]  size;
   logic        unsigned_ld;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        ready;
   logic        rvalid;
   logic [31:0] rdata;
   logic        err;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        is_ld;
      logic [31:0] rd;
      logic        er;
      string       name;
   } exp_t;

   typedef struct {
      logic        vld;
      logic [31:0] rd;
      logic        er;
   } obs_t;

   exp_t sb[$];
   obs_t obs[$];

   mips_data_mem #(.DEPTH(16)) dut (
      .clk         (clk),
      .resetb      (resetb),
      .req         (req),
      .we          (we),
      .size        (size),
      .unsigned_ld (unsigned_ld),
      .addr        (addr),
      .wdata       (wdata),
      .ready       (ready),
      .rvalid      (rvalid),
      .rdata       (rdata),
      .err         (err)
   );

   always #5 clk = ~clk;

   // Drive one access for one cycle, queue its expectation and capture the response.
   task automatic issue(input string nm, input logic w, input logic [1:0] s, input logic u,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic exp_err);
      exp_t e;
      obs_t o;
      @(negedge clk);
      req = 1'b1; we = w; size = s; unsigned_ld = u; addr = a; wdata = d;
      e.is_ld = !w; e.rd = exp_rd; e.er = exp_err; e.name = nm;
      sb.push_back(e);
      @(posedge clk);
      #1;
      o.vld = rvalid; o.rd = rdata; o.er = err;
      obs.push_back(o);
      req = 1'b0;
   endtask

   task automatic test_reset();
      int n;
      int spur;
      @(negedge clk);
      checks++; if (ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b want=0", ready); end
      checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL rst_rvalid got=%b want=0", rvalid); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b want=0", err); end
      checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h want=00000000", rdata); end
      resetb = 1'b1;
      req = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h0;
      n = 0; spur = 0;
      while (n < 200) begin
         @(posedge clk);
         #1;
         n++;
         if (rvalid || err) spur++;
         if (ready) break;
      end
      req = 1'b0;
      checks++; if (n !== 16) begin failures++; $display("FAIL init_len got=%0d want=16", n); end
      checks++; if (spur !== 0) begin failures++; $display("FAIL init_drop got=%0d want=0", spur); end
   endtask

   task automatic test_init_zero();
      exp_t e;
      obs_t o;
      for (int i = 0; i < 16; i++) issue("init_zero", 1'b0, 2'b10, 1'b0, 32'(4*i), 32'h0, 32'h0, 1'b0);
      while (sb.size() > 0) begin
         e = sb.pop_front(); o = obs.pop_front();
         checks++; if (o.vld !== e.is_ld || o.er !== e.er || (e.is_ld && o.rd !== e.rd)) begin
            failures++; $display("FAIL %s got vld=%b err=%b rd=%h want vld=%b err=%b rd=%h",
                                 e.name, o.vld, o.er, o.rd, e.is_ld, e.er, e.rd);
         end
      end
   endtask

   task automatic test_byte();
      exp_t e;
      obs_t o;
      issue("sw_8",   1'b1, 2'b10, 1'b0, 32'h8, 32'h11223344, 32'h0, 1'b0);
      issue("lb_9",   1'b0, 2'b00, 1'b0, 32'h9, 32'h0, 32'h00000033, 1'b0);
      issue("lb_b",   1'b0, 2'b00, 1'b0, 32'hB, 32'h0, 32'h00000011, 1'b0);
      issue("lbu_b",  1'b0, 2'b00, 1'b1, 32'hB, 32'h0, 32'h00000011, 1'b0);
      issue("sb_a",   1'b1, 2'b00, 1'b0, 32'hA, 32'h000000F0, 32'h0, 1'b0);
      issue("lb_a",   1'b0, 2'b00, 1'b0, 32'hA, 32'h0, 32'hFFFFFFF0, 1'b0);
      issue("lbu_a",  1'b0, 2'b00, 1'b1, 32'hA, 32'h0, 32'h000000F0, 1'b0);
      issue("lw_8",   1'b0, 2'b10, 1'b1, 32'h8, 32'h0, 32'h11F03344, 1'b0);
      while (sb.size() > 0) begin
         e = sb.pop_front(); o = obs.pop_front();
         checks++; if (o.vld !== e.is_ld || o.er !== e.er || (e.is_ld && o.rd !== e.rd)) begin
            failures++; $display("FAIL %s got vld=%b err=%b rd=%h want vld=%b err=%b rd=%h",
                                 e.name, o.vld, o.er, o.rd, e.is_ld, e.er, e.rd);
         end
      end
   endtask

   task automatic test_half();
      exp_t e;
      obs_t o;
      issue("sw_4",   1'b1, 2'b10, 1'b0, 32'h4, 32'h55667788, 32'h0, 1'b0);
      issue("sh_6",   1'b1, 2'b01, 1'b0, 32'h6, 32'hABCD8001, 32'h0, 1'b0);
      issue("lh_6",   1'b0, 2'b01, 1'b0, 32'h6, 32'h0, 32'hFFFF8001, 1'b0);
      issue("lhu_6",  1'b0, 2'b01, 1'b1, 32'h6, 32'h0, 32'h00008001, 1'b0);
      issue("lw_4",   1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h80017788, 1'b0);
      issue("lh_4",   1'b0, 2'b01, 1'b0, 32'h4, 32'h0, 32'h00007788, 1'b0);
      issue("lb_4",   1'b0, 2'b00, 1'b0, 32'h4, 32'h0, 32'hFFFFFF88, 1'b0);
      while (sb.size() > 0) begin
         e = sb.pop_front(); o = obs.pop_front();
         checks++; if (o.vld !== e.is_ld || o.er !== e.er || (e.is_ld && o.rd !== e.rd)) begin
            failures++; $display("FAIL %s got vld=%b err=%b rd=%h want vld=%b err=%b rd=%h",
                                 e.name, o.vld, o.er, o.rd, e.is_ld, e.er, e.rd);
         end
      end
   endtask

   task automatic test_illegal();
      exp_t e;
      obs_t o;
      issue("lw_mis2",  1'b0, 2'b10, 1'b0, 32'h2, 32'h0, 32'h0, 1'b1);
      issue("sh_mis5",  1'b1, 2'b01, 1'b0, 32'h5, 32'h0000FFFF, 32'h0, 1'b1);
      issue("lw_4_chk", 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h80017788, 1'b0);
      issue("ld_sz11",  1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
      issue("st_sz11",  1'b1, 2'b11, 1'b0, 32'h8, 32'hFFFFFFFF, 32'h0, 1'b1);
      issue("lh_mis1",  1'b0, 2'b01, 1'b0, 32'h1, 32'h0, 32'h0, 1'b1);
      issue("lw_8_chk", 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'h11F03344, 1'b0);
      while (sb.size() > 0) begin
         e = sb.pop_front(); o = obs.pop_front();
         checks++; if (o.vld !== e.is_ld || o.er !== e.er || (e.is_ld && o.rd !== e.rd)) begin
            failures++; $display("FAIL %s got vld=%b err=%b rd=%h want vld=%b err=%b rd=%h",
                                 e.name, o.vld, o.er, o.rd, e.is_ld, e.er, e.rd);
         end
      end
      // With no request, rvalid drops and rdata keeps the last load result.
      @(posedge clk);
      #1;
      checks++; if (rvalid !== 1'b0 || err !== 1'b0) begin
         failures++; $display("FAIL idle_pulse got rvalid=%b err=%b want 0 0", rvalid, err);
      end
      checks++; if (rdata !== 32'h11F03344) begin
         failures++; $display("FAIL rdata_hold got=%h want=11f03344", rdata);
      end
   endtask

   task automatic test_range();
      exp_t e;
      obs_t o;
      issue("sw_0",     1'b1, 2'b10, 1'b0, 32'h0,  32'h01020304, 32'h0, 1'b0);
      issue("sw_40",    1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D, 32'h0, 1'b1);
      issue("lw_0",     1'b0, 2'b10, 1'b0, 32'h0,  32'h0, 32'h01020304, 1'b0);
      issue("lw_40",    1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h0, 1'b1);
      issue("lb_top",   1'b0, 2'b00, 1'b0, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b1);
      issue("lw_3c",    1'b0, 2'b10, 1'b0, 32'h3C, 32'h0, 32'h0, 1'b0);
      while (sb.size() > 0) begin
         e = sb.pop_front(); o = obs.pop_front();
         checks++; if (o.vld !== e.is_ld || o.er !== e.er || (e.is_ld && o.rd !== e.rd)) begin
            failures++; $display("FAIL %s got vld=%b err=%b rd=%h want vld=%b err=%b rd=%h",
                                 e.name, o.vld, o.er, o.rd, e.is_ld, e.er, e.rd);
         end
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      obs_t o;
      issue("b2b_sw",  1'b1, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0);
      issue("b2b_lw",  1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0);
      issue("b2b_sb",  1'b1, 2'b00, 1'b0, 32'h3, 32'h0000007F, 32'h0, 1'b0);
      issue("b2b_lb",  1'b0, 2'b00, 1'b0, 32'h3, 32'h0, 32'h0000007F, 1'b0);
      issue("b2b_lhu", 1'b0, 2'b01, 1'b1, 32'h2, 32'h0, 32'h00007FAD, 1'b0);
      issue("b2b_lb1", 1'b0, 2'b00, 1'b0, 32'h1, 32'h0, 32'hFFFFFFBE, 1'b0);
      while (sb.size() > 0) begin
         e = sb.pop_front(); o = obs.pop_front();
         checks++; if (o.vld !== e.is_ld || o.er !== e.er || (e.is_ld && o.rd !== e.rd)) begin
            failures++; $display("FAIL %s got vld=%b err=%b rd=%h want vld=%b err=%b rd=%h",
                                 e.name, o.vld, o.er, o.rd, e.is_ld, e.er, e.rd);
         end
      end
   endtask

   task automatic test_reset_mid_init();
      int n;
      // Load in flight when reset hits: its response must be discarded.
      @(negedge clk);
      req = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h0;
      @(posedge clk);
      #1;
      req = 1'b0;
      resetb = 1'b0;
      #1;
      checks++; if (rvalid !== 1'b0 || rdata !== 32'h0 || err !== 1'b0 || ready !== 1'b0) begin
         failures++; $display("FAIL reset_run got rvalid=%b err=%b ready=%b rd=%h want 0 0 0 0",
                              rvalid, err, ready, rdata);
      end
      @(negedge clk);
      resetb = 1'b1;
      repeat (7) @(posedge clk);
      @(negedge clk);
      checks++; if (ready !== 1'b0) begin failures++; $display("FAIL mid_init_ready got=%b want=0", ready); end
      resetb = 1'b0;
      @(negedge clk);
      resetb = 1'b1;
      n = 0;
      while (n < 200) begin
         @(posedge clk);
         #1;
         n++;
         if (ready) break;
      end
      checks++; if (n !== 16) begin failures++; $display("FAIL restart_len got=%0d want=16", n); end
      issue("post_rst_lw0", 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      begin
         exp_t e;
         obs_t o;
         e = sb.pop_front(); o = obs.pop_front();
         checks++; if (o.vld !== e.is_ld || o.er !== e.er || o.rd !== e.rd) begin
            failures++; $display("FAIL %s got vld=%b err=%b rd=%h want vld=%b err=%b rd=%h",
                                 e.name, o.vld, o.er, o.rd, e.is_ld, e.er, e.rd);
         end
      end
   endtask

   initial begin
      resetb = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; unsigned_ld = 1'b0;
      addr = 32'h0; wdata = 32'h0;
      repeat (3) @(posedge clk);
      test_reset();
      test_init_zero();
      test_byte();
      test_half();
      test_illegal();
      test_range();
      test_back_to_back();
      test_reset_mid_init();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
